// File: rtl/upower_fetch_unit_if.sv
// Fetch-unit bundle: imem request/response, core redirect and issue.
// master = fetch unit side, slave = memory/core side.
interface upower_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_WIDTH-1:0] imem_req_addr;
  logic                imem_resp_valid;
  logic [31:0]         imem_resp_data;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                inst_valid;
  logic [31:0]         inst_data;
  logic [PC_WIDTH-1:0] inst_pc;
  logic                inst_ready;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/upower_fetch_unit.sv
// uPower fetch stage: credit-limited imem requests, in-order prefetch
// FIFO with exact PCs, and redirect flush with wrong-path response drop.
module upower_fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                 clock,
  input logic                 reset_n,
  upower_fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t              r_state;
  logic                r_run;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_pcq [FIFO_DEPTH];
  logic [AW-1:0]       r_pcq_wp;
  logic [AW-1:0]       r_pcq_rp;
  logic [31:0]         r_dat [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] r_pc  [FIFO_DEPTH];
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_outst;
  logic [CW-1:0]       r_drop;

  logic          w_redir;
  logic          w_credit;
  logic          w_req;
  logic          w_acc;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_outst_nxt;

  // Buffered plus in-flight never exceeds depth, so a response
  // always finds a free FIFO slot.
  assign w_redir  = bus.redirect_valid;
  assign w_credit = ({1'b0, r_count} + {1'b0, r_outst}) < DEPTH;
  assign w_req    = r_run & ~w_redir & w_credit;
  assign w_acc    = w_req & bus.imem_req_ready;
  assign w_rsp    = bus.imem_resp_valid;
  assign w_push   = w_rsp & ~w_redir & (r_state == FETCH);
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & bus.inst_ready & ~w_redir;

  assign w_outst_nxt = r_outst + CW'(w_acc) - CW'(w_rsp);

  assign bus.imem_req_valid = w_req;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = ~w_empty;
  assign bus.inst_data      = w_empty ? '0 : r_dat[r_head];
  assign bus.inst_pc        = w_empty ? '0 : r_pc[r_head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FETCH;
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_pcq_wp   <= '0;
      r_pcq_rp   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pcq[i] <= '0;
        r_dat[i] <= '0;
        r_pc[i]  <= '0;
      end
    end else begin
      r_run   <= 1'b1;
      r_outst <= w_outst_nxt;

      if (w_redir) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_acc) begin
        r_fetch_pc <= r_fetch_pc + PC_WIDTH'(1);
      end

      // PC queue tracks every in-flight request, dropped or not.
      if (w_acc) begin
        r_pcq[r_pcq_wp] <= r_fetch_pc;
        r_pcq_wp        <= r_pcq_wp + AW'(1);
      end
      if (w_rsp) begin
        r_pcq_rp <= r_pcq_rp + AW'(1);
      end

      if (w_redir) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_drop  <= w_outst_nxt;
        r_state <= (w_outst_nxt != '0) ? DRAIN : FETCH;
      end else begin
        if (w_push) begin
          r_dat[r_tail] <= bus.imem_resp_data;
          r_pc[r_tail]  <= r_pcq[r_pcq_rp];
          r_tail        <= r_tail + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (r_state == DRAIN && w_rsp) begin
          r_drop <= r_drop - CW'(1);
          if (r_drop == CW'(1)) begin
            r_state <= FETCH;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_upower_fetch_unit.sv
// Directed bench for upower_fetch_unit: in-order memory model with
// hold control, scoreboard of expected {pc,data} popped on issue.
module tb_upower_fetch_unit;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  upower_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

  upower_fetch_unit #(
    .PC_WIDTH  (PW),
    .FIFO_DEPTH(4),
    .RESET_PC  ('0)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  acc_cnt = 0;
  int  gaps;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Memory: accepts sampled at negedge, response at the earliest
  // one cycle after acceptance, in order, unless held.
  logic          mem_hold = 1'b0;
  logic [PW-1:0] mem_q[$];
  logic          mem_acc;
  logic [PW-1:0] mem_addr;

  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_acc  = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      mem_addr = bus.imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        bus.imem_resp_valid = 1'b0;
      end else begin
        if (mem_acc) mem_q.push_back(mem_addr);
        if (!mem_hold && mem_q.size() > 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = f(mem_q.pop_front());
        end else begin
          bus.imem_resp_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) acc_cnt = 0;
    else if (bus.imem_req_valid && bus.imem_req_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb_t e;
    e.pc  = pc;
    e.dat = f(pc);
    sb.push_back(e);
  endtask

  task automatic take(input int n, input int budget, output int g);
    int   got;
    int   cyc;
    sb_t  e;
    got = 0;
    cyc = 0;
    g   = 0;
    while (got < n && cyc < budget) begin
      if (bus.inst_valid) begin
        bus.inst_ready = 1'b1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_underflow: got pc %h want none", bus.inst_pc);
        end else begin
          e = sb.pop_front();
          chk("inst_pc", bus.inst_pc, e.pc);
          chk("inst_data", bus.inst_data, e.dat);
        end
        got++;
      end else begin
        bus.inst_ready = 1'b0;
        if (got > 0) g++;
      end
      tick();
      cyc++;
    end
    bus.inst_ready = 1'b0;
    chk("take_count", got, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);

    // Streaming fetch from PC 0
    for (int i = 0; i < 8; i++) expect_pc(i);
    rst_n = 1'b1;
    tick();
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr", bus.imem_req_addr, 0);
    take(8, 40, gaps);
    chk("stream_gaps", gaps, 0);

    // Core stalled: credits cap requests at depth
    do_reset();
    repeat (12) tick();
    chk("stall_accepts", acc_cnt, 4);
    chk("stall_req_valid", bus.imem_req_valid, 0);
    chk("stall_inst_valid", bus.inst_valid, 1);
    chk("stall_inst_pc", bus.inst_pc, 0);
    for (int i = 0; i < 6; i++) expect_pc(i);
    take(1, 10, gaps);
    #1;
    chk("resume_req_valid", bus.imem_req_valid, 1);
    chk("resume_req_addr", bus.imem_req_addr, 4);
    take(5, 40, gaps);

    // Redirect with 5,6,7 in flight
    bus.imem_req_ready = 1'b0;
    mem_hold = 1'b1;
    do_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd5;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    repeat (3) tick();
    bus.imem_req_ready = 1'b0;
    #1;
    chk("held_req_valid", bus.imem_req_valid, 1);
    chk("held_req_addr", bus.imem_req_addr, 8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    chk("redir_no_req", bus.imem_req_valid, 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("post_redir_inst_valid", bus.inst_valid, 0);
    mem_hold = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_pc(32'h40 + i);
    take(3, 40, gaps);

    // Redirect coinciding with a response and a pop
    repeat (8) tick();
    chk("full_req_valid", bus.imem_req_valid, 0);
    expect_pc(32'h43);
    take(1, 10, gaps);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    bus.inst_ready     = 1'b1;
    #1;
    chk("coinc_req_valid", bus.imem_req_valid, 0);
    chk("coinc_inst_valid", bus.inst_valid, 1);
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    #1;
    chk("coinc_flushed", bus.inst_valid, 0);
    expect_pc(32'h80);
    expect_pc(32'h81);
    take(2, 30, gaps);

    // PC wrap
    do_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_hi", bus.imem_req_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_addr_lo", bus.imem_req_addr, 0);
    expect_pc(32'hFFFF_FFFF);
    expect_pc(32'h0);
    take(2, 30, gaps);

    // Async reset with 2 buffered and 1 outstanding
    do_reset();
    repeat (4) tick();
    bus.imem_req_ready = 1'b0;
    #1;
    chk("pre_reset_valid", bus.inst_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_inst_valid", bus.inst_valid, 0);
    chk("async_inst_pc", bus.inst_pc, 0);
    chk("async_req_valid", bus.imem_req_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    tick();
    chk("restart_req_valid", bus.imem_req_valid, 1);
    chk("restart_req_addr", bus.imem_req_addr, 0);
    expect_pc(32'h0);
    expect_pc(32'h1);
    take(2, 30, gaps);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
